requant_pipeline: RTL and testbench
===================================

Name: requant_pipeline

Overview:
- Parametrised, multi-lane successor of the CFU fixed-point requantiser.
- Converts LANES signed 32-bit accumulators into OUT_W-bit activations, one beat per cycle:
  - saturating rounding doubling high multiply;
  - rounding divide by power of two;
  - output offset;
  - activation clamp.
- Fully pipelined with valid/ready backpressure. Per-beat capture of configuration allows reconfiguration while beats are in flight.
- Sits between the SIMD MAC accumulators and the CFU response path.

Parameters:
- LANES, 4, number of parallel 32-bit lanes per beat (1..8).
- OUT_W, 8, signed output width per lane (2..32).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- cfg_we  in  1  load config registers this cycle.
- cfg_multiplier  in  32  signed Q31 quantized multiplier.
- cfg_shift  in  6  signed shift, range -31..+31.
- cfg_offset  in  32  signed output offset.
- cfg_act_min  in  OUT_W  signed clamp lower bound.
- cfg_act_max  in  OUT_W  signed clamp upper bound.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_x  in  LANES*32  packed signed accumulators; lane i = [32i+31:32i].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_y  out  LANES*OUT_W  packed signed results; lane i = [OUT_W*i+OUT_W-1:OUT_W*i].

Behaviour:
- Reset: asynchronous, active-high. Clears all stage valids.
  - out_valid=0, out_y=0.
  - Config reset values: multiplier 0x40000000, shift 0, offset 0, min -2^(OUT_W-1), max 2^(OUT_W-1)-1.
- Reset mid-operation discards all in-flight beats; no output is produced for them.
- Pipeline: 4 stages (S1 multiply, S2 nudge/high, S3 rounding shift, S4 offset/clamp). Latency is exactly 4 cycles from accept to out_valid when unstalled.
- Advance and handshake:
  - adv = ~out_valid | out_ready; in_ready = adv.
  - All stages move together when adv=1 and hold their contents when adv=0.
  - Bubbles are carried, not compressed.
  - out_y is stable while out_valid&&!out_ready.
- Config:
  - cfg_we updates the registers at the clock edge.
  - A beat captures config at acceptance; config travels with the beat.
  - A beat accepted in the same cycle as cfg_we uses the old config.
- Arithmetic, per lane, 32-bit signed:
  - ls = max(shift,0); rs = max(-shift,0).
  - a = x<<ls, wrapping to 32 bits.
  - SRDHM: if a==b==0x80000000, the result is 0x7FFFFFFF. Otherwise p=a*b (64-bit), nudge = p>=0 ? 2^30 : 1-2^30, h = (p+nudge)/2^31 truncated toward zero.
  - RDPOT: mask=(1<<rs)-1, rem=h&mask, thr=(mask>>1)+(h<0), r=(h>>>rs)+(rem>thr).
  - Offset add: v = r+offset in 33-bit signed, no wrap.
  - Clamp: y = min(max(v,act_min),act_max). If act_min>act_max, y=act_max.
- shift outside -31..+31 is illegal; output undefined, but it must not hang or corrupt other beats.
- Lanes are independent and use identical config.

Optional Feature:
- Macro REQUANT_BIAS_EN.
- When defined:
  - Adds port in_bias (in, LANES*32, per-lane signed bias, sampled with in_x).
  - Bias is added to x with 32-bit wrap before the left shift.
  - Latency is unchanged; the add is folded into S1.
- When undefined: the port is absent and x is used directly.

Test Plan:
- Default config, in_x lanes {100,-100,0,1}, out_ready=1 -> out_y {50,-50,0,1} exactly 4 cycles after accept.
- cfg shift=-2, offset=-128, mult=0x40000000; x=100 -> h=50 -> r=13 -> y=-115. Lanes are independent: x=-100 -> y=-141, clamped to -128.
- x=0x80000000, mult=0x80000000, shift 0, offset 0 -> SRDHM saturates to 0x7FFFFFFF -> clamp to 127. mult=0x7FFFFFFF, x=1000 -> 127.
- Offer 6 back-to-back beats with out_ready=0 for 10 cycles -> exactly 4 accepted, in_ready=0, out_y stable. After release, all 6 emerge in order with no loss or duplication.
- cfg_we with shift 0→-1 in the acceptance cycle of beat B, with beats A then B then C -> A and B use shift 0; C uses -1 (x=100 -> 25).
- Assert reset while 3 beats are in flight -> out_valid drops immediately. After release, no stale beats appear and config returns to reset values.

Source files
------------

// File: rtl/requant_pipeline.sv
// Multi-lane fixed-point requantiser: SRDHM, rounding shift, offset, clamp in a 4-stage pipeline.
// Optional REQUANT_BIAS_EN adds a per-lane in_bias port summed into x ahead of the left shift.
module requant_pipeline #(
  parameter int LANES = 4,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [31:0]            cfg_multiplier,
  input  logic [5:0]             cfg_shift,
  input  logic [31:0]            cfg_offset,
  input  logic [OUT_W-1:0]       cfg_act_min,
  input  logic [OUT_W-1:0]       cfg_act_max,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*32-1:0]    in_x,
`ifdef REQUANT_BIAS_EN
  input  logic [LANES*32-1:0]    in_bias,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_y
);

  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = 64'sd1 - NUDGE_POS;
  localparam logic [OUT_W-1:0]   MIN_RST   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]   MAX_RST   = {1'b0, {(OUT_W-1){1'b1}}};

  logic [31:0]      mult_q;
  logic [5:0]       shift_q;
  logic [31:0]      off_q;
  logic [OUT_W-1:0] min_q, max_q;

  logic             adv, acc;
  logic             v1, v2, v3;
  logic [4:0]       ls_c;
  logic [5:0]       rs_c;

  logic [5:0]       s1_rs, s2_rs;
  logic [31:0]      s1_off, s2_off, s3_off;
  logic [OUT_W-1:0] s1_min, s2_min, s3_min;
  logic [OUT_W-1:0] s1_max, s2_max, s3_max;
  logic signed [32:0] min33, max33;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign acc      = in_valid & adv;

  // Negative shift selects the rounding right shift; positive selects the pre-multiply left shift.
  assign ls_c = shift_q[5] ? 5'd0 : shift_q[4:0];
  assign rs_c = shift_q[5] ? (6'd0 - shift_q) : 6'd0;

  assign min33 = {{(33-OUT_W){s3_min[OUT_W-1]}}, s3_min};
  assign max33 = {{(33-OUT_W){s3_max[OUT_W-1]}}, s3_max};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_q  <= 32'h4000_0000;
      shift_q <= 6'd0;
      off_q   <= 32'd0;
      min_q   <= MIN_RST;
      max_q   <= MAX_RST;
    end else if (cfg_we) begin
      mult_q  <= cfg_multiplier;
      shift_q <= cfg_shift;
      off_q   <= cfg_offset;
      min_q   <= cfg_act_min;
      max_q   <= cfg_act_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
    end
  end

  // Config sampled at acceptance rides along with each beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_rs  <= 6'd0;
      s1_off <= 32'd0;
      s1_min <= MIN_RST;
      s1_max <= MAX_RST;
      s2_rs  <= 6'd0;
      s2_off <= 32'd0;
      s2_min <= MIN_RST;
      s2_max <= MAX_RST;
      s3_off <= 32'd0;
      s3_min <= MIN_RST;
      s3_max <= MAX_RST;
    end else begin
      if (acc) begin
        s1_rs  <= rs_c;
        s1_off <= off_q;
        s1_min <= min_q;
        s1_max <= max_q;
      end
      if (adv && v1) begin
        s2_rs  <= s1_rs;
        s2_off <= s1_off;
        s2_min <= s1_min;
        s2_max <= s1_max;
      end
      if (adv && v2) begin
        s3_off <= s2_off;
        s3_min <= s2_min;
        s3_max <= s2_max;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0]        x, a;
    logic signed [63:0] p;
    logic               sat;
    logic signed [63:0] s1_p, s;
    logic               s1_sat;
    logic [31:0]        q, h, s2_h;
    logic [31:0]        mask, rem, thr, r, s3_r;
    logic signed [31:0] sh;
    logic signed [32:0] v;
    logic [OUT_W-1:0]   y, y_q;

`ifdef REQUANT_BIAS_EN
    assign x = in_x[32*i +: 32] + in_bias[32*i +: 32];
`else
    assign x = in_x[32*i +: 32];
`endif
    assign a   = x << ls_c;
    assign p   = $signed({{32{a[31]}}, a}) * $signed({{32{mult_q[31]}}, mult_q});
    assign sat = (a == 32'h8000_0000) && (mult_q == 32'h8000_0000);

    // Floor quotient from the bit slice, then bump negatives with a remainder toward zero.
    assign s = s1_p + (s1_p[63] ? NUDGE_NEG : NUDGE_POS);
    assign q = s[62:31];
    assign h = s1_sat ? 32'h7FFF_FFFF : ((s[63] && |s[30:0]) ? q + 32'd1 : q);

    assign mask = 32'hFFFF_FFFF >> (6'd32 - s2_rs);
    assign rem  = s2_h & mask;
    assign thr  = {1'b0, mask[31:1]} + {31'd0, s2_h[31]};
    assign sh   = $signed(s2_h) >>> s2_rs;
    assign r    = sh + {31'd0, (rem > thr)};

    assign v = $signed({s3_r[31], s3_r}) + $signed({s3_off[31], s3_off});
    assign y = ((v > max33) || (min33 > max33)) ? s3_max :
               (v < min33) ? s3_min : v[OUT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_p   <= '0;
        s1_sat <= 1'b0;
        s2_h   <= '0;
        s3_r   <= '0;
        y_q    <= '0;
      end else begin
        if (acc) begin
          s1_p   <= p;
          s1_sat <= sat;
        end
        if (adv && v1) s2_h <= h;
        if (adv && v2) s3_r <= r;
        if (adv && v3) y_q  <= y;
      end
    end

    assign out_y[OUT_W*i +: OUT_W] = y_q;
  end

endmodule

// File: tb/tb_requant_pipeline.sv
// Directed bench for requant_pipeline (LANES=4, OUT_W=8) with hand-computed expected vectors.
module tb_requant_pipeline;
  logic         clk = 1'b0;
  logic         reset, cfg_we;
  logic [31:0]  cfg_multiplier, cfg_offset;
  logic [5:0]   cfg_shift;
  logic [7:0]   cfg_act_min, cfg_act_max;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_x;
  logic [31:0]  out_y;
`ifdef REQUANT_BIAS_EN
  logic [127:0] in_bias = '0;
`endif

  int n_chk = 0, n_pass = 0, n_fail = 0;

  logic [127:0] bx [6];
  logic [31:0]  by [6];
  logic [31:0]  q [$];
  logic [31:0]  snap, g;
  int           bi, stray;
  bit           stable, seen;

  always #5 clk = ~clk;

  requant_pipeline #(.LANES(4), .OUT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we),
    .cfg_multiplier(cfg_multiplier), .cfg_shift(cfg_shift), .cfg_offset(cfg_offset),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
`ifdef REQUANT_BIAS_EN
    .in_bias(in_bias),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  function automatic logic [127:0] px(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] py(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] m, input int sh, input int off, input int mn, input int mx);
    cfg_we = 1'b1;
    cfg_multiplier = m;
    cfg_shift = sh[5:0];
    cfg_offset = off;
    cfg_act_min = mn[7:0];
    cfg_act_max = mx[7:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [127:0] x, input logic [31:0] exp);
    int lat;
    logic [31:0] got;
    in_valid = 1'b1;
    in_x = x;
    #1;
    chk({tag, "_rdy"}, 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    got = '0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (out_valid && lat < 0) begin
        lat = k;
        got = out_y;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, 128'(lat), 128'd4);
    chk({tag, "_y"}, 128'(got), 128'(exp));
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_multiplier = '0; cfg_shift = '0; cfg_offset = '0;
    cfg_act_min = '0; cfg_act_max = '0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ov", 128'(out_valid), 128'd0);
    chk("rst_y", 128'(out_y), 128'd0);
    chk("rst_rdy", 128'(in_ready), 128'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    send_one("dflt", px(100, -100, 0, 1), py(50, -50, 0, 1));
    set_cfg(32'h4000_0000, -2, -128, -128, 127);
    send_one("rdpot", px(100, -100, 0, 1), py(-115, -128, -128, -128));
    set_cfg(32'h8000_0000, 0, 0, -128, 127);
    send_one("sat", px(int'(32'h8000_0000), 100, 0, -1), py(127, -100, 0, 1));
    set_cfg(32'h7FFF_FFFF, 0, 0, -128, 127);
    send_one("maxm", px(1000, -1000, 50, -3), py(127, -128, 50, -3));
    set_cfg(32'h4000_0000, 2, 0, -128, 127);
    send_one("lshift", px(100, 10, -7, 3), py(127, 20, -14, 6));
    set_cfg(32'h4000_0000, 0, 0, 10, -10);
    send_one("inv", px(100, -100, 0, 1), py(-10, -10, -10, -10));
    set_cfg(32'h4000_0000, 0, 0, -128, 127);

    // Backpressure: 6 beats offered while downstream stalls for 10 cycles.
    for (int i = 0; i < 6; i++) begin
      bx[i] = px(2 * (10 + i), -2 * (10 + i), 2 * i, 4 * i);
      by[i] = py(10 + i, -(10 + i), i, 2 * i);
    end
    bi = 0; stable = 1'b1; seen = 1'b0; snap = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (bi < 6);
      in_x = bx[(bi < 6) ? bi : 5];
      #1;
      if (in_valid && in_ready) bi++;
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          snap = out_y;
        end else if (out_y !== snap) stable = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    chk("bp_acc", 128'(bi), 128'd4);
    chk("bp_rdy", 128'(in_ready), 128'd0);
    chk("bp_stable", 128'({seen, stable}), 128'd3);
    chk("bp_head", 128'(snap), 128'(by[0]));
    @(negedge clk);
    out_ready = 1'b1;
    q.delete();
    for (int c = 0; c < 30 && q.size() < 6; c++) begin
      in_valid = (bi < 6);
      in_x = bx[(bi < 6) ? bi : 5];
      #1;
      if (out_valid && out_ready) q.push_back(out_y);
      if (in_valid && in_ready) bi++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) stray++;
      @(negedge clk);
    end
    chk("bp_count", 128'(q.size()), 128'd6);
    chk("bp_extra", 128'(stray), 128'd0);
    for (int i = 0; i < 6; i++) begin
      g = (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
      chk($sformatf("bp_beat%0d", i), 128'(g), 128'(by[i]));
    end

    // Config written in the acceptance cycle of B applies from C onward.
    in_valid = 1'b1;
    in_x = px(100, -100, 0, 1);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_shift = 6'h3F;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    q.delete();
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid && out_ready) q.push_back(out_y);
      @(negedge clk);
    end
    chk("mid_count", 128'(q.size()), 128'd3);
    for (int i = 0; i < 3; i++) begin
      g = (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
      chk($sformatf("mid_beat%0d", i), 128'(g),
          128'((i < 2) ? py(50, -50, 0, 1) : py(25, -25, 0, 1)));
    end

    // Reset with three beats in flight under a non-default config.
    set_cfg(32'h4000_0000, -1, 5, -128, 127);
    in_valid = 1'b1;
    in_x = px(100, -100, 0, 1);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_ov", 128'(out_valid), 128'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ov", 128'(out_valid), 128'd0);
    chk("mid_rst_y", 128'(out_y), 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) stray++;
      @(negedge clk);
    end
    chk("post_rst_stray", 128'(stray), 128'd0);
    send_one("post_rst", px(100, -100, 0, 1), py(50, -50, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
